// File: rtl/tlb.sv
// Fully associative TLB with two concurrent registered search ports, one write port and a combinational read port.
// Optional per-port miss counters are enabled by defining TLB_MISS_CNT_EN.
module tlb #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_req,
  input  logic [18:0]             s0_vpn2,
  input  logic                    s0_odd_page,
  input  logic [7:0]              s0_asid,
  output logic                    s0_rvalid,
  output logic                    s0_found,
  output logic [TLBNUM_WIDTH-1:0] s0_index,
  output logic [19:0]             s0_pfn,
  output logic [2:0]              s0_c,
  output logic                    s0_d,
  output logic                    s0_v,
  input  logic                    s1_req,
  input  logic [18:0]             s1_vpn2,
  input  logic                    s1_odd_page,
  input  logic [7:0]              s1_asid,
  output logic                    s1_rvalid,
  output logic                    s1_found,
  output logic [TLBNUM_WIDTH-1:0] s1_index,
  output logic [19:0]             s1_pfn,
  output logic [2:0]              s1_c,
  output logic                    s1_d,
  output logic                    s1_v,
  output logic [TLBNUM_WIDTH:0]   tlbp_result,
  input  logic                    we,
  input  logic [TLBNUM_WIDTH-1:0] w_index,
  input  logic [18:0]             w_vpn2,
  input  logic [7:0]              w_asid,
  input  logic                    w_g,
  input  logic [19:0]             w_pfn0,
  input  logic [2:0]              w_c0,
  input  logic                    w_d0,
  input  logic                    w_v0,
  input  logic [19:0]             w_pfn1,
  input  logic [2:0]              w_c1,
  input  logic                    w_d1,
  input  logic                    w_v1,
  input  logic [TLBNUM_WIDTH-1:0] r_index,
  output logic [18:0]             r_vpn2,
  output logic [7:0]              r_asid,
  output logic                    r_g,
  output logic [19:0]             r_pfn0,
  output logic [2:0]              r_c0,
  output logic                    r_d0,
  output logic                    r_v0,
  output logic [19:0]             r_pfn1,
  output logic [2:0]              r_c1,
  output logic                    r_d1,
  output logic                    r_v1,
  output logic [31:0]             s0_miss_cnt,
  output logic [31:0]             s1_miss_cnt
);
  localparam int NP = 2;

  logic [TLBNUM-1:0] e_q, e_d;
  logic [18:0]       vpn2_q [TLBNUM];
  logic [7:0]        asid_q [TLBNUM];
  logic              g_q    [TLBNUM];
  logic [19:0]       pfn0_q [TLBNUM];
  logic [2:0]        c0_q   [TLBNUM];
  logic              d0_q   [TLBNUM];
  logic              v0_q   [TLBNUM];
  logic [19:0]       pfn1_q [TLBNUM];
  logic [2:0]        c1_q   [TLBNUM];
  logic              d1_q   [TLBNUM];
  logic              v1_q   [TLBNUM];

  // Payload is never reset; only the present bits are cleared.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      vpn2_q[w_index] <= w_vpn2;
      asid_q[w_index] <= w_asid;
      g_q[w_index]    <= w_g;
      pfn0_q[w_index] <= w_pfn0;
      c0_q[w_index]   <= w_c0;
      d0_q[w_index]   <= w_d0;
      v0_q[w_index]   <= w_v0;
      pfn1_q[w_index] <= w_pfn1;
      c1_q[w_index]   <= w_c1;
      d1_q[w_index]   <= w_d1;
      v1_q[w_index]   <= w_v1;
    end
  end

  always_comb begin
    e_d = e_q;
    if (we) e_d[w_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) e_q <= '0;
    else       e_q <= e_d;
  end

  assign r_vpn2 = vpn2_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_pfn0 = pfn0_q[r_index];
  assign r_c0   = c0_q[r_index];
  assign r_d0   = d0_q[r_index];
  assign r_v0   = v0_q[r_index];
  assign r_pfn1 = pfn1_q[r_index];
  assign r_c1   = c1_q[r_index];
  assign r_d1   = d1_q[r_index];
  assign r_v1   = v1_q[r_index];

  logic [NP-1:0]     sk_req, sk_odd;
  logic [18:0]       sk_vpn2 [NP];
  logic [7:0]        sk_asid [NP];

  assign sk_req     = {s1_req, s0_req};
  assign sk_odd     = {s1_odd_page, s0_odd_page};
  assign sk_vpn2[0] = s0_vpn2;
  assign sk_vpn2[1] = s1_vpn2;
  assign sk_asid[0] = s0_asid;
  assign sk_asid[1] = s1_asid;

  logic [NP-1:0]          hit;
  logic [TLBNUM_WIDTH-1:0] hidx [NP];
  logic [19:0]            hpfn [NP];
  logic [2:0]             hc   [NP];
  logic [NP-1:0]          hd, hv;

  // Scan from the top down so the lowest matching index is the last one kept.
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      hit[k]  = 1'b0;
      hidx[k] = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (e_q[i] && (vpn2_q[i] == sk_vpn2[k]) && (g_q[i] || (asid_q[i] == sk_asid[k]))) begin
          hit[k]  = 1'b1;
          hidx[k] = TLBNUM_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      hpfn[k] = '0;
      hc[k]   = '0;
      hd[k]   = 1'b0;
      hv[k]   = 1'b0;
      if (hit[k]) begin
        if (sk_odd[k]) begin
          hpfn[k] = pfn1_q[hidx[k]];
          hc[k]   = c1_q[hidx[k]];
          hd[k]   = d1_q[hidx[k]];
          hv[k]   = v1_q[hidx[k]];
        end else begin
          hpfn[k] = pfn0_q[hidx[k]];
          hc[k]   = c0_q[hidx[k]];
          hd[k]   = d0_q[hidx[k]];
          hv[k]   = v0_q[hidx[k]];
        end
      end
    end
  end

  logic [NP-1:0]           rvalid_q, rvalid_d, found_q, found_d;
  logic [NP-1:0]           dirty_q, dirty_d, valid_q, valid_d;
  logic [TLBNUM_WIDTH-1:0] index_q [NP];
  logic [TLBNUM_WIDTH-1:0] index_d [NP];
  logic [19:0]             pfn_q [NP];
  logic [19:0]             pfn_d [NP];
  logic [2:0]              c_q [NP];
  logic [2:0]              c_d [NP];

  // Results hold their last value on cycles without a request.
  always_comb begin
    rvalid_d = sk_req;
    found_d  = found_q;
    dirty_d  = dirty_q;
    valid_d  = valid_q;
    index_d  = index_q;
    pfn_d    = pfn_q;
    c_d      = c_q;
    for (int k = 0; k < NP; k++) begin
      if (sk_req[k]) begin
        found_d[k] = hit[k];
        index_d[k] = hidx[k];
        pfn_d[k]   = hpfn[k];
        c_d[k]     = hc[k];
        dirty_d[k] = hd[k];
        valid_d[k] = hv[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= '0;
      found_q  <= '0;
      dirty_q  <= '0;
      valid_q  <= '0;
      for (int k = 0; k < NP; k++) begin
        index_q[k] <= '0;
        pfn_q[k]   <= '0;
        c_q[k]     <= '0;
      end
    end else begin
      rvalid_q <= rvalid_d;
      found_q  <= found_d;
      dirty_q  <= dirty_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
      pfn_q    <= pfn_d;
      c_q      <= c_d;
    end
  end

  assign s0_rvalid   = rvalid_q[0];
  assign s0_found    = found_q[0];
  assign s0_index    = index_q[0];
  assign s0_pfn      = pfn_q[0];
  assign s0_c        = c_q[0];
  assign s0_d        = dirty_q[0];
  assign s0_v        = valid_q[0];
  assign s1_rvalid   = rvalid_q[1];
  assign s1_found    = found_q[1];
  assign s1_index    = index_q[1];
  assign s1_pfn      = pfn_q[1];
  assign s1_c        = c_q[1];
  assign s1_d        = dirty_q[1];
  assign s1_v        = valid_q[1];
  assign tlbp_result = {~found_q[1], index_q[1]};

`ifdef TLB_MISS_CNT_EN
  logic [31:0] miss_cnt_q [NP];
  logic [31:0] miss_cnt_d [NP];

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      miss_cnt_d[k] = miss_cnt_q[k] + {31'b0, sk_req[k] & ~hit[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NP; k++) miss_cnt_q[k] <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign s0_miss_cnt = miss_cnt_q[0];
  assign s1_miss_cnt = miss_cnt_q[1];
`else
  assign s0_miss_cnt = '0;
  assign s1_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_tlb.sv
// Bench for tlb: directed scenarios plus random traffic against an associative-array model of the TLB.
module tb_tlb;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s0_req, s0_odd_page, s1_req, s1_odd_page;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_rvalid, s0_found, s0_d, s0_v, s1_rvalid, s1_found, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic [4:0]  tlbp_result;
  logic        we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  w_index, r_index;
  logic [18:0] w_vpn2, r_vpn2;
  logic [7:0]  w_asid, r_asid;
  logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  w_c0, w_c1, r_c0, r_c1;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;
  logic [31:0] s0_miss_cnt, s1_miss_cnt;

  tlb #(.TLBNUM(N)) dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .tlbp_result(tlbp_result),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .s0_miss_cnt(s0_miss_cnt), .s1_miss_cnt(s1_miss_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } ent_t;

  ent_t        mem [N];
  bit          present [N];
  bit          written [N];
  bit          exp_rvalid [2];
  bit          exp_found [2];
  logic [3:0]  exp_idx [2];
  logic [19:0] exp_pfn [2];
  logic [2:0]  exp_c [2];
  bit          exp_d [2];
  bit          exp_v [2];
  bit [31:0]   exp_miss [2];

  task automatic model_search(input int k, input logic [18:0] vpn, input logic [7:0] asid, input logic odd);
    int h;
    h = -1;
    for (int i = 0; i < N; i++)
      if (h < 0 && present[i] && mem[i].vpn2 == vpn && (mem[i].g || mem[i].asid == asid)) h = i;
    exp_rvalid[k] = 1;
    if (h < 0) begin
      exp_found[k] = 0; exp_idx[k] = 0; exp_pfn[k] = 0; exp_c[k] = 0; exp_d[k] = 0; exp_v[k] = 0;
`ifdef TLB_MISS_CNT_EN
      exp_miss[k] = exp_miss[k] + 1;
`endif
    end else begin
      exp_found[k] = 1;
      exp_idx[k]   = 4'(h);
      exp_pfn[k]   = odd ? mem[h].pfn1 : mem[h].pfn0;
      exp_c[k]     = odd ? mem[h].c1 : mem[h].c0;
      exp_d[k]     = odd ? mem[h].d1 : mem[h].d0;
      exp_v[k]     = odd ? mem[h].v1 : mem[h].v0;
    end
  endtask

  // Advance the model by one clock edge: searches see pre-write contents.
  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < N; i++) present[i] = 0;
      for (int k = 0; k < 2; k++) begin
        exp_rvalid[k] = 0; exp_found[k] = 0; exp_idx[k] = 0; exp_pfn[k] = 0;
        exp_c[k] = 0; exp_d[k] = 0; exp_v[k] = 0; exp_miss[k] = 0;
      end
    end else begin
      if (s0_req) model_search(0, s0_vpn2, s0_asid, s0_odd_page);
      else        exp_rvalid[0] = 0;
      if (s1_req) model_search(1, s1_vpn2, s1_asid, s1_odd_page);
      else        exp_rvalid[1] = 0;
      if (we) begin
        mem[w_index] = {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1};
        present[w_index] = 1;
        written[w_index] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("s0_rvalid", s0_rvalid, exp_rvalid[0]);
    check("s0_found", s0_found, exp_found[0]);
    check("s0_index", s0_index, exp_idx[0]);
    check("s0_pfn", s0_pfn, exp_pfn[0]);
    check("s0_cdv", {s0_c, s0_d, s0_v}, {exp_c[0], exp_d[0], exp_v[0]});
    check("s1_rvalid", s1_rvalid, exp_rvalid[1]);
    check("s1_found", s1_found, exp_found[1]);
    check("s1_index", s1_index, exp_idx[1]);
    check("s1_pfn", s1_pfn, exp_pfn[1]);
    check("s1_cdv", {s1_c, s1_d, s1_v}, {exp_c[1], exp_d[1], exp_v[1]});
    check("tlbp", tlbp_result, {~exp_found[1], exp_idx[1]});
    check("s0_miss_cnt", s0_miss_cnt, exp_miss[0]);
    check("s1_miss_cnt", s1_miss_cnt, exp_miss[1]);
    if (written[r_index])
      check("r_fields", {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1},
            mem[r_index]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_write(input logic [3:0] idx, input logic [18:0] vpn, input logic [7:0] asid,
                           input logic g, input logic [19:0] p0, input logic [19:0] p1);
    we = 1; w_index = idx; w_vpn2 = vpn; w_asid = asid; w_g = g;
    w_pfn0 = p0; w_c0 = 0; w_d0 = 0; w_v0 = 1;
    w_pfn1 = p1; w_c1 = 0; w_d1 = 0; w_v1 = 1;
  endtask

  task automatic set_s(input int k, input logic req, input logic [18:0] vpn, input logic [7:0] asid, input logic odd);
    if (k == 0) begin s0_req = req; s0_vpn2 = vpn; s0_asid = asid; s0_odd_page = odd; end
    else        begin s1_req = req; s1_vpn2 = vpn; s1_asid = asid; s1_odd_page = odd; end
  endtask

  logic [18:0] vpool [4];
  logic [7:0]  apool [3];
  logic [31:0] exp_cnt;

  initial begin
    vpool = '{19'h12345, 19'h00100, 19'h7ffff, 19'h00001};
    apool = '{8'h05, 8'h07, 8'h08};
    for (int i = 0; i < N; i++) begin present[i] = 0; written[i] = 0; end
    set_s(0, 0, 0, 0, 0);
    set_s(1, 0, 0, 0, 0);
    we = 0; w_index = 0; w_vpn2 = 0; w_asid = 0; w_g = 0;
    w_pfn0 = 0; w_c0 = 0; w_d0 = 0; w_v0 = 0; w_pfn1 = 0; w_c1 = 0; w_d1 = 0; w_v1 = 0;
    r_index = 0;
    reset = 1;
    cycle();
    cycle();
    check("rst_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
    check("rst_tlbp", tlbp_result, 5'h10);
    reset = 0;

    // First search after reset misses.
    set_s(0, 1, 19'h00001, 8'h05, 0);
    cycle();
    check("first_rvalid", s0_rvalid, 1'b1);
    check("first_found", s0_found, 1'b0);
    check("first_tlbp4", tlbp_result[4], 1'b1);
    set_s(0, 0, 0, 0, 0);

    // Odd-page hit and ASID mismatch.
    set_write(4'd3, 19'h12345, 8'h07, 0, 20'hAAAAA, 20'hBBBBB);
    r_index = 4'd3;
    cycle();
    we = 0;
    check("rd_vpn2", r_vpn2, 19'h12345);
    check("rd_pfn1", r_pfn1, 20'hBBBBB);
    set_s(1, 1, 19'h12345, 8'h07, 1);
    cycle();
    check("hit_found", s1_found, 1'b1);
    check("hit_index", s1_index, 4'd3);
    check("hit_pfn", s1_pfn, 20'hBBBBB);
    check("hit_tlbp", tlbp_result, 5'h03);
    set_s(1, 1, 19'h12345, 8'h08, 1);
    cycle();
    check("asid_miss", s1_found, 1'b0);
    set_s(1, 0, 0, 0, 0);
    cycle();
    check("hold_rvalid", s1_rvalid, 1'b0);
    check("hold_found", s1_found, 1'b0);

    // Two global entries, lowest index wins on both ports at once.
    set_write(4'd5, 19'h2AAAA, 8'h01, 1, 20'h11111, 20'h55555);
    cycle();
    set_write(4'd2, 19'h2AAAA, 8'h02, 1, 20'h22222, 20'h66666);
    cycle();
    we = 0;
    set_s(0, 1, 19'h2AAAA, 8'h33, 0);
    set_s(1, 1, 19'h2AAAA, 8'h99, 1);
    cycle();
    check("multi_idx0", s0_index, 4'd2);
    check("multi_pfn0", s0_pfn, 20'h22222);
    check("multi_idx1", s1_index, 4'd2);
    check("multi_pfn1", s1_pfn, 20'h66666);
    set_s(1, 0, 0, 0, 0);

    // Search concurrent with the write sees old contents.
    set_write(4'd4, 19'h00100, 8'h05, 0, 20'h0C0C0, 20'h0D0D0);
    set_s(0, 1, 19'h00100, 8'h05, 0);
    cycle();
    we = 0;
    check("wr_same_cyc", s0_found, 1'b0);
    cycle();
    check("wr_next_found", s0_found, 1'b1);
    check("wr_next_idx", s0_index, 4'd4);
    set_s(0, 0, 0, 0, 0);

    // Reset clears E but not payload.
    r_index = 4'd3;
    reset = 1;
    cycle();
    reset = 0;
    set_s(1, 1, 19'h12345, 8'h07, 1);
    cycle();
    check("post_rst_miss", s1_found, 1'b0);
    check("post_rst_rvpn", r_vpn2, 19'h12345);
    set_s(1, 0, 0, 0, 0);

    // Miss counting: three misses and one hit on s1.
    reset = 1;
    cycle();
    reset = 0;
    set_write(4'd6, 19'h3C3C3, 8'h01, 0, 20'h00001, 20'h00002);
    cycle();
    we = 0;
    for (int i = 0; i < 3; i++) begin
      set_s(1, 1, 19'h0AAAA, 8'h01, 0);
      cycle();
    end
    set_s(1, 1, 19'h3C3C3, 8'h01, 0);
    cycle();
    set_s(1, 0, 0, 0, 0);
    cycle();
`ifdef TLB_MISS_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    check("miss_cnt_s1", s1_miss_cnt, exp_cnt);
    check("miss_cnt_s0", s0_miss_cnt, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      we      = ($urandom_range(0, 2) == 0);
      w_index = 4'($urandom_range(0, 15));
      w_vpn2  = vpool[$urandom_range(0, 3)];
      w_asid  = apool[$urandom_range(0, 2)];
      w_g     = ($urandom_range(0, 3) == 0);
      w_pfn0  = 20'($urandom);
      w_c0    = 3'($urandom_range(0, 7));
      w_d0    = 1'($urandom_range(0, 1));
      w_v0    = 1'($urandom_range(0, 1));
      w_pfn1  = 20'($urandom);
      w_c1    = 3'($urandom_range(0, 7));
      w_d1    = 1'($urandom_range(0, 1));
      w_v1    = 1'($urandom_range(0, 1));
      set_s(0, ($urandom_range(0, 3) != 0), vpool[$urandom_range(0, 3)],
            apool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
      set_s(1, ($urandom_range(0, 3) != 0), vpool[$urandom_range(0, 3)],
            apool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
      r_index = 4'($urandom_range(0, 15));
      cycle();
    end
    reset = 0;
    we = 0;
    set_s(0, 0, 0, 0, 0);
    set_s(1, 0, 0, 0, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
